aes_inv_key_sched: RTL and testbench

AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

---
 rtl/aes_inv_key_sched.sv | 145 ++++++++++++++
 tb/tb_aes_inv_key_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_sched.sv
// Backward AES-128 key schedule: starting from a round key, emits it and each earlier
// round key down to round 0 over a valid/ready handshake. Optional macro:
// AES_INV_KEY_LOAD_ROUND_EN loads the starting round from `times` (clamped to 10).
module aes_inv_key_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [3:0]   times,
    input  logic         out_ready,
    output logic         key_valid,
    output logic [127:0] key_out,
    output logic [3:0]   round_out,
    output logic         busy,
    output logic         done
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

    state_e         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     round_q, round_d;
    logic [3:0]     start_round;
    logic [7:0]     rcon;
    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    p0, p1, p2, p3;
    logic [31:0]    rot;
    logic [31:0]    sub;
    logic [127:0]   prev_key;

`ifdef AES_INV_KEY_LOAD_ROUND_EN
    assign start_round = (times > 4'd10) ? 4'd10 : times;
`else
    logic unused_times;
    assign unused_times = ^times;
    assign start_round  = 4'd10;
`endif

    // Rcon is indexed by the round being undone, i.e. the currently held round.
    always_comb begin
        unique case (round_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign {w0, w1, w2, w3} = key_q;
    assign p3  = w3 ^ w2;
    assign p2  = w2 ^ w1;
    assign p1  = w1 ^ w0;
    assign rot = {p3[23:0], p3[31:24]};
    assign sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    assign p0  = w0 ^ sub ^ {rcon, 24'h0};
    assign prev_key = {p0, p1, p2, p3};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = start_round;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    if (round_q == 4'd0) begin
                        state_d = StDone;
                    end else begin
                        key_d   = prev_key;
                        round_d = round_q - 4'd1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            key_q   <= 128'h0;
            round_q <= 4'h0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    assign key_valid = (state_q == StEmit);
    assign busy      = (state_q == StEmit);
    assign done      = (state_q == StDone);
    assign key_out   = key_q;
    assign round_out = round_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: expected keys come from a forward AES-128 expansion built on an
// arithmetically derived S-box (GF(2^8) inverse plus affine map).
module tb_aes_inv_key_sched;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic [3:0]   times;
    logic         out_ready;
    logic         key_valid;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sb_tab [256];
    logic [127:0] rk [11];

    aes_inv_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .times     (times),
        .out_ready (out_ready),
        .key_valid (key_valid),
        .key_out   (key_out),
        .round_out (round_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                        ^ 8'h63;
        end
    endtask

    // Forward expansion from the round-0 key fills rk[0..10].
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    task automatic do_sched(input logic [3:0] tms, input int first, input int stall_r,
                            input int stall_n, input bit poke, input string tag);
        start     = 1'b1;
        times     = tms;
        key_in    = rk[first];
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = first; r >= 0; r--) begin
            chk($sformatf("%s r%0d valid", tag, r), 128'(key_valid), 128'd1);
            chk($sformatf("%s r%0d round", tag, r), 128'(round_out), 128'(r));
            chk($sformatf("%s r%0d key", tag, r), key_out, rk[r]);
            chk($sformatf("%s r%0d busy", tag, r), 128'(busy), 128'd1);
            chk($sformatf("%s r%0d done", tag, r), 128'(done), 128'd0);
            if (r == stall_r) begin
                out_ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    @(negedge clk);
                    chk($sformatf("%s stall%0d key", tag, k), key_out, rk[r]);
                    chk($sformatf("%s stall%0d round", tag, k), 128'(round_out), 128'(r));
                    chk($sformatf("%s stall%0d valid", tag, k), 128'(key_valid), 128'd1);
                end
                out_ready = 1'b1;
            end
            if (poke && (r == 5 || r == 0)) begin
                start  = 1'b1;
                key_in = ~key_in;
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk({tag, " done pulse"}, 128'(done), 128'd1);
        chk({tag, " done valid"}, 128'(key_valid), 128'd0);
        chk({tag, " done busy"}, 128'(busy), 128'd0);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " idle done"}, 128'(done), 128'd0);
        chk({tag, " idle valid"}, 128'(key_valid), 128'd0);
        chk({tag, " idle busy"}, 128'(busy), 128'd0);
    endtask

    initial begin
        logic [3:0] tr;
        int         fr;
        rst_n     = 1'b1;
        start     = 1'b0;
        key_in    = '0;
        times     = 4'd0;
        out_ready = 1'b1;
        build_sbox();
        #1 rst_n = 1'b0;
        #2;
        chk("rst valid", 128'(key_valid), 128'd0);
        chk("rst busy", 128'(busy), 128'd0);
        chk("rst done", 128'(done), 128'd0);
        chk("rst key", key_out, 128'h0);
        chk("rst round", 128'(round_out), 128'h0);
        start  = 1'b1;
        key_in = rnd128();
        repeat (2) @(negedge clk);
        chk("rst hold valid", 128'(key_valid), 128'd0);
        chk("rst hold key", key_out, 128'h0);
        start = 1'b0;

        // FIPS-197 vector, start on the first edge after reset release.
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("model r10", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rk[9] = 128'hac7766f319fadc2128d12941575c006e;
        rk[1] = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rst_n = 1'b1;
        do_sched(4'd10, 10, -1, 0, 1'b0, "fips");

        // Back-to-back: start in the first idle cycle after DONE.
        expand(rnd128());
        do_sched(4'd10, 10, 6, 3, 1'b0, "stall");
        expand(rnd128());
        do_sched(4'd10, 10, -1, 0, 1'b1, "poke");

        tr = 4'($urandom_range(0, 15));
`ifdef AES_INV_KEY_LOAD_ROUND_EN
        fr = (tr > 4'd10) ? 10 : int'(tr);
`else
        fr = 10;
`endif
        expand(rnd128());
        do_sched(tr, fr, (fr > 2) ? 2 : -1, 2, 1'b0, "times");

        // Reset mid-schedule at round 4.
        expand(rnd128());
        start  = 1'b1;
        times  = 4'd10;
        key_in = rk[10];
        @(negedge clk);
        start = 1'b0;
        for (int r = 10; r > 4; r--) @(negedge clk);
        chk("mid round4", 128'(round_out), 128'd4);
        chk("mid key4", key_out, rk[4]);
        rst_n = 1'b0;
        #1;
        chk("abort valid", 128'(key_valid), 128'd0);
        chk("abort busy", 128'(busy), 128'd0);
        chk("abort key", key_out, 128'h0);
        chk("abort round", 128'(round_out), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort nodone%0d", k), 128'(done), 128'd0);
            chk($sformatf("abort idle%0d", k), 128'(key_valid), 128'd0);
        end
        expand(rnd128());
        do_sched(4'd10, 10, -1, 0, 1'b0, "fresh");

`ifdef AES_INV_KEY_LOAD_ROUND_EN
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        do_sched(4'd1, 1, -1, 0, 1'b0, "t1");
        do_sched(4'd15, 10, -1, 0, 1'b0, "t15");
        expand(rnd128());
        do_sched(4'd0, 0, -1, 0, 1'b0, "t0");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
